lsu_mem_port: RTL and testbench

Load/store unit that sits directly upstream of the byte-addressable data memory. It accepts one load or store request at a time from the core over a valid/ready handshake and decodes RISC-V width/sign (funct3) into the memory's byte write strobes. It sign- or zero-extends load data and reports illegal, misaligned or out-of-range accesses as an error response without touching memory. The memory adds byte offsets 0..3 to its address internally, so this block drives the raw byte address and unshifted data.

---
 rtl/lsu_mem_port_if.sv | 31 +++
 rtl/lsu_mem_port.sv | 141 ++++++++++++++
 tb/tb_lsu_mem_port.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_if.sv
// Core/memory bundle of the load/store unit: request and response handshakes plus the
// byte-addressed memory port. The LSU takes the slave side, the core/memory model the master side.
interface lsu_mem_port_if #(
  parameter int ADDR_BITS = 10
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [2:0]           req_funct3;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;
  logic [3:0]           mem_w_enb;
  logic                 mem_r_enb;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [31:0]          mem_w_data;
  logic [31:0]          mem_r_data;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_r_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_w_enb, mem_r_enb, mem_addr, mem_w_data
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_r_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_w_enb, mem_r_enb, mem_addr, mem_w_data
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store unit: decodes funct3 into byte strobes, extends load data,
// and turns illegal/misaligned/out-of-range requests into error responses without a memory access.
module lsu_mem_port #(
  parameter int ADDR_BITS   = 10,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_port_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [32:0] MEM_TOP = 33'((33'd1 << ADDR_BITS) - 33'd1);

  logic [1:0]           state_q,  state_d;
  logic                 we_q,     we_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [ADDR_BITS-1:0] addr_q,   addr_d;
  logic [31:0]          wdata_q,  wdata_d;
  logic [31:0]          rdata_q,  rdata_d;
  logic                 err_q,    err_d;

  logic [32:0] accSize;
  logic [32:0] lastByte;
  logic        funct3Legal;
  logic        misaligned;
  logic        outOfRange;
  logic        reqErr;
  logic [31:0] loadData;
  logic [3:0]  storeStrobe;
  logic        inAccess;

  // Request screening; the last byte is computed in 33 bits so addresses near 2**32 cannot wrap.
  always_comb begin
    accSize = 33'd1;
    case (bus.req_funct3[1:0])
      2'b01:   accSize = 33'd2;
      2'b10:   accSize = 33'd4;
      default: accSize = 33'd1;
    endcase
    lastByte   = {1'b0, bus.req_addr} + accSize - 33'd1;
    outOfRange = (lastByte > MEM_TOP);
    if (bus.req_we) begin
      funct3Legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      funct3Legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    misaligned = CHECK_ALIGN &&
                 (((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                  ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)));
    reqErr = !funct3Legal || misaligned || outOfRange;
  end

  always_comb begin
    loadData = bus.mem_r_data;
    case (funct3_q)
      3'b000:  loadData = {{24{bus.mem_r_data[7]}}, bus.mem_r_data[7:0]};
      3'b001:  loadData = {{16{bus.mem_r_data[15]}}, bus.mem_r_data[15:0]};
      3'b100:  loadData = {24'd0, bus.mem_r_data[7:0]};
      3'b101:  loadData = {16'd0, bus.mem_r_data[15:0]};
      default: loadData = bus.mem_r_data;
    endcase
    storeStrobe = 4'b0000;
    case (funct3_q[1:0])
      2'b00:   storeStrobe = 4'b0001;
      2'b01:   storeStrobe = 4'b0011;
      2'b10:   storeStrobe = 4'b1111;
      default: storeStrobe = 4'b0000;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr[ADDR_BITS-1:0];
          wdata_d  = bus.req_wdata;
          rdata_d  = 32'd0;
          err_d    = reqErr;
          state_d  = reqErr ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = loadData;
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Every output is gated by rst so a reset mid-access suppresses the memory write at that edge.
  assign inAccess       = rst && (state_q == ACCESS);
  assign bus.req_ready  = rst && (state_q == IDLE);
  assign bus.rsp_valid  = rst && (state_q == RESP);
  assign bus.rsp_rdata  = bus.rsp_valid ? rdata_q : 32'd0;
  assign bus.rsp_err    = bus.rsp_valid && err_q;
  assign bus.mem_w_enb  = (inAccess && we_q) ? storeStrobe : 4'b0000;
  assign bus.mem_r_enb  = inAccess && !we_q;
  assign bus.mem_addr   = inAccess ? addr_q : '0;
  assign bus.mem_w_data = inAccess ? wdata_q : 32'd0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: an aligned-checking instance with a byte memory model
// and a non-checking instance fed a fixed read word.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        useB = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqWe = 1'b0;
  logic [2:0]  reqFunct3 = 3'd0;
  logic [31:0] reqAddr = 32'd0;
  logic [31:0] reqWdata = 32'd0;
  logic        rspReady = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic [7:0]  mem [0:1023];

  always #5 clk = ~clk;

  lsu_mem_port_if #(.ADDR_BITS(10)) busA ();
  lsu_mem_port_if #(.ADDR_BITS(10)) busB ();

  lsu_mem_port #(.ADDR_BITS(10), .CHECK_ALIGN(1'b1)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(busA.slave)
  );

  lsu_mem_port #(.ADDR_BITS(10), .CHECK_ALIGN(1'b0)) u_dutNoAlign (
    .clk(clk),
    .rst(rst),
    .bus(busB.slave)
  );

  assign busA.req_valid  = reqValid & ~useB;
  assign busA.req_we     = reqWe;
  assign busA.req_funct3 = reqFunct3;
  assign busA.req_addr   = reqAddr;
  assign busA.req_wdata  = reqWdata;
  assign busA.rsp_ready  = rspReady;
  assign busA.mem_r_data = {mem[busA.mem_addr + 10'd3], mem[busA.mem_addr + 10'd2],
                            mem[busA.mem_addr + 10'd1], mem[busA.mem_addr]};

  assign busB.req_valid  = reqValid & useB;
  assign busB.req_we     = reqWe;
  assign busB.req_funct3 = reqFunct3;
  assign busB.req_addr   = reqAddr;
  assign busB.req_wdata  = reqWdata;
  assign busB.rsp_ready  = rspReady;
  assign busB.mem_r_data = 32'h11223344;

  // Byte memory applies offsets 0..3 to the raw address, as the real data memory does.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (busA.mem_w_enb[i]) begin
        mem[busA.mem_addr + 10'(i)] <= busA.mem_w_data[8*i +: 8];
      end
    end
  end

  logic        oReqReady, oRspValid, oRspErr, oMemREnb;
  logic [31:0] oRspRdata, oMemWData;
  logic [3:0]  oMemWEnb;
  logic [9:0]  oMemAddr;

  always_comb begin
    oReqReady = useB ? busB.req_ready  : busA.req_ready;
    oRspValid = useB ? busB.rsp_valid  : busA.rsp_valid;
    oRspErr   = useB ? busB.rsp_err    : busA.rsp_err;
    oRspRdata = useB ? busB.rsp_rdata  : busA.rsp_rdata;
    oMemWEnb  = useB ? busB.mem_w_enb  : busA.mem_w_enb;
    oMemREnb  = useB ? busB.mem_r_enb  : busA.mem_r_enb;
    oMemAddr  = useB ? busB.mem_addr   : busA.mem_addr;
    oMemWData = useB ? busB.mem_w_data : busA.mem_w_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata);
    reqWe     = we;
    reqFunct3 = f3;
    reqAddr   = addr;
    reqWdata  = wdata;
    reqValid  = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "/req_ready"}, 32'(oReqReady), 32'd0);
    checkOutput({tag, "/rsp_valid"}, 32'(oRspValid), 32'd0);
    checkOutput({tag, "/rsp_rdata"}, oRspRdata, 32'd0);
    checkOutput({tag, "/rsp_err"}, 32'(oRspErr), 32'd0);
    checkOutput({tag, "/mem_w_enb"}, 32'(oMemWEnb), 32'd0);
    checkOutput({tag, "/mem_r_enb"}, 32'(oMemREnb), 32'd0);
    checkOutput({tag, "/mem_addr"}, 32'(oMemAddr), 32'd0);
    checkOutput({tag, "/mem_w_data"}, oMemWData, 32'd0);
  endtask

  // One full transaction with rsp_ready already high, so the block is back in IDLE afterwards.
  task automatic runReq(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic expErr,
                        input logic [31:0] expRdata, input logic [3:0] expWenb);
    @(negedge clk);
    checkOutput({tag, "/req_ready"}, 32'(oReqReady), 32'd1);
    applyStimulus(we, f3, addr, wdata);
    rspReady = 1'b1;
    @(negedge clk);
    reqValid = 1'b0;
    if (!expErr) begin
      checkOutput({tag, "/acc_rsp_valid"}, 32'(oRspValid), 32'd0);
      checkOutput({tag, "/mem_w_enb"}, 32'(oMemWEnb), 32'(expWenb));
      checkOutput({tag, "/mem_r_enb"}, 32'(oMemREnb), 32'(!we));
      checkOutput({tag, "/mem_addr"}, 32'(oMemAddr), 32'(addr[9:0]));
      if (we) checkOutput({tag, "/mem_w_data"}, oMemWData, wdata);
      @(negedge clk);
    end else begin
      checkOutput({tag, "/err_w_enb"}, 32'(oMemWEnb), 32'd0);
      checkOutput({tag, "/err_r_enb"}, 32'(oMemREnb), 32'd0);
    end
    checkOutput({tag, "/rsp_valid"}, 32'(oRspValid), 32'd1);
    checkOutput({tag, "/rsp_err"}, 32'(oRspErr), 32'(expErr));
    checkOutput({tag, "/rsp_rdata"}, oRspRdata, expRdata);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_reset/req_ready", 32'(oReqReady), 32'd1);

    runReq("sw_010",  1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 1'b0, 32'd0,        4'b1111);
    runReq("lw_010",  1'b0, 3'b010, 32'h010, 32'd0,        1'b0, 32'hDEADBEEF, 4'b0000);
    runReq("sb_021",  1'b1, 3'b000, 32'h021, 32'h000000F0, 1'b0, 32'd0,        4'b0001);
    runReq("lb_021",  1'b0, 3'b000, 32'h021, 32'd0,        1'b0, 32'hFFFFFFF0, 4'b0000);
    runReq("lbu_021", 1'b0, 3'b100, 32'h021, 32'd0,        1'b0, 32'h000000F0, 4'b0000);
    runReq("sh_042",  1'b1, 3'b001, 32'h042, 32'h00008001, 1'b0, 32'd0,        4'b0011);
    runReq("lh_042",  1'b0, 3'b001, 32'h042, 32'd0,        1'b0, 32'hFFFF8001, 4'b0000);
    runReq("lhu_042", 1'b0, 3'b101, 32'h042, 32'd0,        1'b0, 32'h00008001, 4'b0000);
    runReq("lw_013",  1'b0, 3'b010, 32'h013, 32'd0,        1'b1, 32'd0,        4'b0000);
    runReq("sh_041",  1'b1, 3'b001, 32'h041, 32'h00001234, 1'b1, 32'd0,        4'b0000);
    runReq("sw_3fc",  1'b1, 3'b010, 32'h3FC, 32'h12345678, 1'b0, 32'd0,        4'b1111);
    runReq("lw_3fc",  1'b0, 3'b010, 32'h3FC, 32'd0,        1'b0, 32'h12345678, 4'b0000);
    runReq("lw_3fd",  1'b0, 3'b010, 32'h3FD, 32'd0,        1'b1, 32'd0,        4'b0000);
    runReq("sb_400",  1'b1, 3'b000, 32'h400, 32'h000000AA, 1'b1, 32'd0,        4'b0000);
    runReq("s_f3_100", 1'b1, 3'b100, 32'h010, 32'h00000055, 1'b1, 32'd0,       4'b0000);
    runReq("l_f3_011", 1'b0, 3'b011, 32'h010, 32'd0,        1'b1, 32'd0,       4'b0000);

    // Misaligned accesses go through on the instance without alignment checking.
    useB = 1'b1;
    runReq("na_lw_013", 1'b0, 3'b010, 32'h013, 32'd0,        1'b0, 32'h11223344, 4'b0000);
    runReq("na_sh_041", 1'b1, 3'b001, 32'h041, 32'h00008001, 1'b0, 32'd0,        4'b0011);
    @(negedge clk);
    useB = 1'b0;

    // Backpressure on the response while the next request is already waiting.
    checkOutput("stall/req_ready", 32'(oReqReady), 32'd1);
    applyStimulus(1'b0, 3'b010, 32'h010, 32'd0);
    rspReady = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 3'b100, 32'h021, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall/rsp_valid", 32'(oRspValid), 32'd1);
      checkOutput("stall/rsp_rdata", oRspRdata, 32'hDEADBEEF);
      checkOutput("stall/req_ready", 32'(oReqReady), 32'd0);
      @(negedge clk);
    end
    rspReady = 1'b1;
    @(negedge clk);
    checkOutput("release/req_ready", 32'(oReqReady), 32'd1);
    checkOutput("release/rsp_valid", 32'(oRspValid), 32'd0);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("pending/mem_r_enb", 32'(oMemREnb), 32'd1);
    checkOutput("pending/mem_addr", 32'(oMemAddr), 32'h021);
    @(negedge clk);
    checkOutput("pending/rsp_valid", 32'(oRspValid), 32'd1);
    checkOutput("pending/rsp_rdata", oRspRdata, 32'h000000F0);

    // Reset asserted during a store ACCESS must leave the memory byte untouched.
    runReq("sb_050", 1'b1, 3'b000, 32'h050, 32'h0000005A, 1'b0, 32'd0, 4'b0001);
    @(negedge clk);
    applyStimulus(1'b1, 3'b000, 32'h050, 32'h000000AB);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("rst_acc/pre_w_enb", 32'(oMemWEnb), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rst_acc/gated_w_enb", 32'(oMemWEnb), 32'd0);
    @(negedge clk);
    checkAllZero("rst_acc");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_rel/req_ready", 32'(oReqReady), 32'd1);
    checkOutput("rst_rel/rsp_valid", 32'(oRspValid), 32'd0);
    runReq("lbu_050", 1'b0, 3'b100, 32'h050, 32'd0, 1'b0, 32'h0000005A, 4'b0000);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
